pll_reset_seq: RTL

//  Reset sequencer sitting directly downstream of the ULX3S/ECP5 PLL wrapper (EHXPLLL).

---
 rtl/pll_reset_pkg.sv | 27 ++
 rtl/pll_reset_seq_sync2.sv | 32 +++
 rtl/pll_reset_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pll_reset_pkg.sv
// ============================================================================
//  Module   : pll_reset_pkg
//  Brief    : Shared types and constants for the PLL reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLLRST    = 3'd4
    } rst_state_t;

    localparam int RELOCK_CNT_W = 8;

    // Saturating increment for the lock-loss event counter.
    function automatic logic [RELOCK_CNT_W-1:0] sat_inc(input logic [RELOCK_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_seq_sync2.sv
// ============================================================================
//  Module   : sync2
//  Brief    : Two-flop synchroniser with asynchronous active-low clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// ============================================================================
//  Module   : pll_reset_seq
//  Brief    : Qualifies ECP5 PLL lock and sequences the core reset; optional
//             watchdog (macro PLL_RST_SEQ_WATCHDOG_EN) pulses EHXPLLL.RST.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int PLLRST_CYCLES  = 25,
    parameter int CNT_W          = 22
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_lock,
    output logic                    pll_rst,
    output logic                    core_rst_n,
    output logic                    locked_ok,
    output logic [RELOCK_CNT_W-1:0] relock_cnt,
    output logic [2:0]              state_o
);

    localparam longint c_cnt_span = longint'(1) << CNT_W;

    if ((STABLE_CYCLES < 1) || (longint'(STABLE_CYCLES) - 1 >= c_cnt_span)) begin : g_chk_stable
        $error("STABLE_CYCLES-1 does not fit in CNT_W");
    end
    if ((HOLD_CYCLES < 1) || (longint'(HOLD_CYCLES) - 1 >= c_cnt_span)) begin : g_chk_hold
        $error("HOLD_CYCLES-1 does not fit in CNT_W");
    end
    if ((TIMEOUT_CYCLES < 1) || (longint'(TIMEOUT_CYCLES) - 1 >= c_cnt_span)) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES-1 does not fit in CNT_W");
    end
    if ((PLLRST_CYCLES < 1) || (longint'(PLLRST_CYCLES) - 1 >= c_cnt_span)) begin : g_chk_pllrst
        $error("PLLRST_CYCLES-1 does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] c_stable_ld = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_ld   = CNT_W'(HOLD_CYCLES - 1);
`ifdef PLL_RST_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pllrst_ld    = CNT_W'(PLLRST_CYCLES - 1);
`endif

    logic                    w_lock_s;
    rst_state_t              r_state;
    rst_state_t              w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_lost;
    logic [RELOCK_CNT_W-1:0] r_relock;
    logic                    r_core_rst_n;
    logic                    r_locked_ok;

    sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // Lock loss is tested before any counter expiry so a drop always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lost      = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = c_stable_ld;
                end else begin
`ifdef PLL_RST_SEQ_WATCHDOG_EN
                    if (r_cnt == c_timeout_last) begin
                        w_state_nxt = ST_PLLRST;
                        w_cnt_nxt   = c_pllrst_ld;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`else
                    w_cnt_nxt = '0;
`endif
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end
            end
`ifdef PLL_RST_SEQ_WATCHDOG_EN
            ST_PLLRST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_relock     <= '0;
            r_core_rst_n <= 1'b0;
            r_locked_ok  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_core_rst_n <= (w_state_nxt == ST_RUN);
            r_locked_ok  <= (w_state_nxt == ST_RUN);
            if (w_lost) begin
                r_relock <= sat_inc(r_relock);
            end
        end
    end

`ifdef PLL_RST_SEQ_WATCHDOG_EN
    logic r_pll_rst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pll_rst <= 1'b0;
        end else begin
            r_pll_rst <= (w_state_nxt == ST_PLLRST);
        end
    end

    assign pll_rst = r_pll_rst;
`else
    assign pll_rst = 1'b0;
`endif

    assign core_rst_n = r_core_rst_n;
    assign locked_ok  = r_locked_ok;
    assign relock_cnt = r_relock;
    assign state_o    = r_state;

endmodule

`default_nettype wire
